// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a small circular input FIFO so a
// producer can queue bytes while a frame is still on the line.
module uart_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUDRATE   = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          data_tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUDRATE;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int TIMER_W    = $clog2(BIT_CYCLES + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DEPTH_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;

    state_t             state_reg;
    state_t             state_next;
    logic [TIMER_W-1:0] timer_reg;
    logic [TIMER_W-1:0] timer_next;
    logic [2:0]         bit_idx_reg;
    logic [2:0]         bit_idx_next;
    logic [7:0]         shift_reg;
    logic [7:0]         shift_next;
    logic               data_tx_reg;
    logic               data_tx_next;
    logic               tx_done_reg;
    logic               tx_done_next;

    logic               push;
    logic               pop;
    logic               bit_end;

    // Ready depends only on the registered count, so a pop in the same
    // cycle never lets a push into a full FIFO.
    assign data_in_ready = (count_reg < DEPTH_CNT);
    assign push          = data_in_valid && data_in_ready;
    assign bit_end       = (timer_reg == TIMER_LAST);

    assign data_tx    = data_tx_reg;
    assign tx_busy    = (state_reg != S_IDLE);
    assign tx_done    = tx_done_reg;
    assign fifo_count = count_reg;

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        data_tx_next = data_tx_reg;
        tx_done_next = 1'b0;
        pop          = 1'b0;

        if (state_reg != S_IDLE) begin
            timer_next = bit_end ? '0 : timer_reg + TIMER_W'(1);
        end

        case (state_reg)
            S_IDLE: begin
                data_tx_next = 1'b1;
                if (count_reg != '0) begin
                    pop          = 1'b1;
                    shift_next   = fifo_mem[rd_ptr_reg];
                    data_tx_next = 1'b0;
                    timer_next   = '0;
                    state_next   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    data_tx_next = shift_reg[0];
                    bit_idx_next = '0;
                    state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == 3'd7) begin
                        data_tx_next = 1'b1;
                        state_next   = S_STOP;
                    end else begin
                        shift_next   = {1'b0, shift_reg[7:1]};
                        data_tx_next = shift_reg[1];
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    tx_done_next = 1'b1;
                    // Queued byte goes straight into a new start bit.
                    if (count_reg != '0) begin
                        pop          = 1'b1;
                        shift_next   = fifo_mem[rd_ptr_reg];
                        data_tx_next = 1'b0;
                        state_next   = S_START;
                    end else begin
                        state_next   = S_IDLE;
                    end
                end
            end
            default: begin
                state_next   = S_IDLE;
                data_tx_next = 1'b1;
            end
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            data_tx_reg <= 1'b1;
            tx_done_reg <= 1'b0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            data_tx_reg <= data_tx_next;
            tx_done_reg <= tx_done_next;
            count_reg   <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_mem[wr_ptr_reg] <= data_in;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit: a line monitor decodes and
// checks every cycle of each frame while the main thread drives the FIFO.
module tb_uart_tx;

    localparam int BIT   = 10;
    localparam int FRAME = 10 * BIT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       data_tx;
    logic       tx_busy;
    logic       tx_done;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int start_cnt = 0;
    bit mon_en = 1'b0;
    bit just_ended = 1'b0;
    bit mon_abort = 1'b0;
    logic [7:0] mon_byte;
    logic       mon_bit;
    logic [7:0] rx_q[$];
    int         st_q[$];

    uart_tx #(
        .CLK_FREQ  (1000),
        .BAUDRATE  (100),
        .FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .data_tx      (data_tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("frames_seen", rx_q.size(), n);
    endtask

    // Line monitor: samples on the falling clock edge, checks each bit is
    // held for exactly BIT cycles, and records the byte and its start cycle.
    always begin
        @(negedge clk);
        if (mon_en && !rst) begin
            if (just_ended) check("done_pulse", tx_done, 1);
            else            check("done_idle", tx_done, 0);
            just_ended = 1'b0;
            if (data_tx == 1'b0) begin
                start_cnt++;
                st_q.push_back(cyc);
                mon_abort = 1'b0;
                mon_byte  = 8'h00;
                mon_bit   = 1'b0;
                for (int b = 0; b < 10 && !mon_abort; b++) begin
                    for (int c = 0; c < BIT && !mon_abort; c++) begin
                        if (b != 0 || c != 0) begin
                            @(negedge clk);
                            if (rst) mon_abort = 1'b1;
                        end
                        if (!mon_abort) begin
                            check("busy_frame", tx_busy, 1);
                            if (b != 0 || c != 0) check("done_frame", tx_done, 0);
                            if (c == 0) mon_bit = data_tx;
                            else        check("bit_hold", data_tx, mon_bit);
                            if (c == 0 && b >= 1 && b <= 8) mon_byte[b-1] = data_tx;
                        end
                    end
                    if (!mon_abort && b == 9) check("stop_bit", mon_bit, 1);
                end
                if (!mon_abort) begin
                    rx_q.push_back(mon_byte);
                    just_ended = 1'b1;
                end
            end else begin
                check("busy_idle", tx_busy, 0);
            end
        end else begin
            just_ended = 1'b0;
        end
    end

    initial begin
        logic [7:0]  fill [5];
        logic [2:0]  exp_cnt [5];
        logic [31:0] got;
        int d0, s0, n0, k, push_cyc;

        fill[0] = 8'hA1; fill[1] = 8'hB2; fill[2] = 8'hC3; fill[3] = 8'hD4; fill[4] = 8'hE5;
        exp_cnt[0] = 3'd0; exp_cnt[1] = 3'd1; exp_cnt[2] = 3'd1; exp_cnt[3] = 3'd2; exp_cnt[4] = 3'd3;

        // Reset values
        repeat (3) tick();
        check("rst_data_tx", data_tx, 1);
        check("rst_ready", data_in_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_count", fifo_count, 0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        repeat (3) tick();

        // Single byte 0x55: one-cycle latency, exact bit timing, one done pulse
        d0 = done_cnt;
        data_in = 8'h55;
        data_in_valid = 1'b1;
        tick();
        push_cyc = cyc;
        data_in_valid = 1'b0;
        check("t1_count_pushed", fifo_count, 1);
        check("t1_line_idle", data_tx, 1);
        check("t1_busy_low", tx_busy, 0);
        tick();
        check("t1_start_edge", data_tx, 0);
        check("t1_count_popped", fifo_count, 0);
        check("t1_busy_high", tx_busy, 1);
        wait_frames(1, FRAME + 50);
        got = (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD;
        $display("t1 frame byte 0x%02h", got[7:0]);
        check("t1_byte", got, 32'h55);
        got = (st_q.size() > 0) ? 32'(st_q[0] - push_cyc) : 32'hDEAD;
        check("t1_latency", got, 1);
        repeat (3) tick();
        check("t1_done_pulses", done_cnt - d0, 1);

        // FIFO fill: five bytes on consecutive cycles, sixth refused
        rx_q.delete();
        st_q.delete();
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            check("t2_ready", data_in_ready, 1);
            check("t2_count", fifo_count, exp_cnt[i]);
            data_in = fill[i];
            data_in_valid = 1'b1;
            tick();
        end
        data_in = 8'hF6;
        check("t2_full_ready", data_in_ready, 0);
        check("t2_full_count", fifo_count, 4);
        k = 0;
        while (!data_in_ready && k < 300) begin
            tick();
            k++;
        end
        data_in_valid = 1'b0;
        check("t2_ready_wait", k, FRAME - 3);
        check("t2_refused_count", fifo_count, 3);
        wait_frames(5, 6 * FRAME);
        for (int i = 0; i < 5; i++) begin
            got = (rx_q.size() > i) ? 32'(rx_q[i]) : 32'hDEAD;
            $display("t2 frame %0d byte 0x%02h", i, got[7:0]);
            check("t2_byte", got, 32'(fill[i]));
            if (i > 0) begin
                got = (st_q.size() > i) ? 32'(st_q[i] - st_q[i-1]) : 32'hDEAD;
                check("t2_spacing", got, FRAME);
            end
        end
        repeat (FRAME + 50) tick();
        check("t2_no_sixth", rx_q.size(), 5);
        check("t2_done_pulses", done_cnt - d0, 5);

        // Wrap-around: 12 bytes through the depth-4 FIFO, with pauses
        rx_q.delete();
        st_q.delete();
        for (int i = 0; i < 12; i++) begin
            data_in = 8'(i);
            data_in_valid = 1'b1;
            k = 0;
            while (!data_in_ready && k < 300) begin
                tick();
                k++;
            end
            check("t3_push_wait", (k < 300) ? 1 : 0, 1);
            tick();
            data_in_valid = 1'b0;
            if (i % 5 == 4) repeat (37) tick();
        end
        wait_frames(12, 14 * FRAME);
        for (int i = 0; i < 12; i++) begin
            got = (rx_q.size() > i) ? 32'(rx_q[i]) : 32'hDEAD;
            $display("t3 frame %0d byte 0x%02h", i, got[7:0]);
            check("t3_byte", got, i);
        end
        repeat (20) tick();

        // Reset during bit 3 of 0xFF with two bytes queued
        rx_q.delete();
        st_q.delete();
        data_in = 8'hFF;
        data_in_valid = 1'b1;
        tick();
        data_in = 8'h12;
        tick();
        data_in = 8'h34;
        tick();
        data_in_valid = 1'b0;
        repeat (42) tick();
        check("t4_pre_count", fifo_count, 2);
        check("t4_pre_busy", tx_busy, 1);
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_data_tx", data_tx, 1);
        check("t4_count", fifo_count, 0);
        check("t4_busy", tx_busy, 0);
        check("t4_done", tx_done, 0);
        check("t4_ready", data_in_ready, 1);
        s0 = start_cnt;
        n0 = rx_q.size();
        repeat (3 * FRAME) tick();
        $display("t4 reset abort, frames after reset %0d", start_cnt - s0);
        check("t4_no_start", start_cnt - s0, 0);
        check("t4_no_frame", rx_q.size() - n0, 0);
        check("t4_no_done", done_cnt - d0, 0);
        check("t4_line_idle", data_tx, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter, 8N1, LSB first, with a small input FIFO so a producer can queue several bytes without waiting for each frame to finish. It is the transmit counterpart of `uart_rx` and drives the FPGA TX pin in the AES encryption/decryption test design. It uses the same `CLK_FREQ`/`BAUDRATE` parameterisation as `uart_rx`, so the two blocks are link-compatible.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUDRATE`, 115_200: line rate in bit/s. `BIT_CYCLES = CLK_FREQ / BAUDRATE`, integer-truncated; 434 at defaults.
- `FIFO_DEPTH`, 4: input FIFO entries. Power of two, ≥ 2.
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `data_in`  input  8  byte to transmit.
- `data_in_valid`  input  1  producer has a byte on `data_in`.
- `data_in_ready`  output  1  FIFO can accept a byte. Equals `count < FIFO_DEPTH` and is driven only from registered state.
- `data_tx`  output  1  serial line. Registered; idles high.
- `tx_busy`  output  1  a frame is on the line; high in START, DATA and STOP.
- `tx_done`  output  1  one-cycle pulse after each stop bit completes.
- `fifo_count`  output  clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted.

## Operation
- Push: a byte is written into the FIFO at a rising edge where `data_in_valid && data_in_ready`. Otherwise `data_in` is ignored. The producer holds `data_in` while valid and not ready.
- When full, `data_in_ready` is 0 and pushes are refused, even if a pop happens in the same cycle.
- Push and pop in the same cycle with FIFO not full: `fifo_count` is unchanged and both operations take effect.
- FIFO is circular. Read and write pointers wrap modulo `FIFO_DEPTH`, with no bubble at the wrap.
- State machine:
  - `S_IDLE`: `data_tx` = 1. If `fifo_count != 0`, pop the head into the shift register, drive `data_tx` = 0, clear the bit timer, and go to `S_START`.
  - `S_START`: hold 0 for `BIT_CYCLES` cycles. Then drive `shift[0]`, set bit index 0, and go to `S_DATA`.
  - `S_DATA`: hold each bit for `BIT_CYCLES` cycles, shifting right. After bit 7 has been held, drive 1 and go to `S_STOP`.
  - `S_STOP`: hold 1 for `BIT_CYCLES` cycles. Then pulse `tx_done` for one cycle. If the FIFO is non-empty at that edge, pop, drive 0 and go to `S_START` (back-to-back frames, no idle gap). Otherwise go to `S_IDLE`.
- Bit timer: counts 0 to `BIT_CYCLES-1`. The bit period ends on the edge where the timer equals `BIT_CYCLES-1`; the timer then reloads to 0.
- Bit index: 3-bit, counts 0 to 7, never wraps within a frame.

## Timing
- Reset values: `data_tx` = 1, `data_in_ready` = 1, `tx_busy` = 0, `tx_done` = 0, `fifo_count` = 0.
- Reset also sets FIFO pointers to 0, state to `S_IDLE`, and timer and bit index to 0.
- Reset mid-frame aborts the frame and discards FIFO contents. `data_tx` is 1 from the reset edge onward, and there is no `tx_done` pulse.
- Latency, empty and idle: byte accepted at edge N → `data_tx` falls at edge N+1 → `fifo_count` returns to 0 at edge N+1.
- Frame length: exactly `10 × BIT_CYCLES` cycles from the start-bit falling edge to the end of the stop bit.
- Bit k (k = 0..7) occupies cycles [(k+1)·BIT_CYCLES, (k+2)·BIT_CYCLES) after the start edge.
- `tx_done` is high for the single cycle following the last stop-bit cycle.
- `tx_busy` rises with the start edge. It falls one cycle after the stop bit ends only when no byte is queued. On back-to-back frames it stays high continuously.
- Maximum throughput: one byte per `10 × BIT_CYCLES` cycles, sustained while the FIFO is non-empty.

## Test plan
- Single byte, `CLK_FREQ`=1000, `BAUDRATE`=100 (10 cycles/bit): push 0x55 at edge 5.
  - `data_tx` = 0 over cycles 6–15, then 1,0,1,0,1,0,1,0 for 10 cycles each, then 1 for 10 cycles.
  - `tx_done` pulses at cycle 106; `tx_busy` falls at cycle 106.
- FIFO fill: hold valid with 0xA1, 0xB2, 0xC3, 0xD4, 0xE5 on consecutive cycles, depth 4.
  - First byte is popped immediately, so all five are accepted.
  - A sixth byte is refused, with `data_in_ready` = 0 until the next pop.
  - Five frames are sent back-to-back with no idle cycle; exactly five `tx_done` pulses.
- Wrap-around: 12 bytes 0x00–0x0B pushed over time through a depth-4 FIFO → bytes emitted in order, none lost or duplicated.
- Reset mid-frame: assert `rst` for 1 cycle during bit 3 of 0xFF with 2 bytes queued.
  - `data_tx` = 1 from the reset edge; `fifo_count` = 0; no `tx_done`; line stays idle afterwards.
- Loopback at defaults: `uart_tx.data_tx` → `uart_rx.data_rx`; send 0x00, 0xFF, 0x3C, 0x81.
  - `uart_rx` reports identical bytes with one `data_out_done` each.
  - Each frame measures 4340 cycles.
